pc_unit: RTL

Parametrised program-counter unit for the RISC-V core: holds the fetch PC, advances it sequentially, and computes branch (PC-relative), JALR (register-relative) and trap redirect targets. It replaces the stand-alone PC+imm target adder with a registered PC, a stall-tolerant pending-redirect buffer, alignment checking and a flush pulse for the front end. It sits between the execute stage, which supplies redirect requests, and instruction fetch, which consumes `PC`.

---
 rtl/pc_unit_if.sv | 33 +++
 rtl/pc_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// pc_unit_if: groups the execute-side redirect requests and the fetch-side
// PC outputs of pc_unit into one bundle.
//   master : execute/fetch side (drives stall and requests, reads PC etc.)
//   slave  : pc_unit itself
// Signals: stall, branchTaken, jalr, exPC, rs1, imm, trapValid, trapVector
//          (requests), PC, linkAddr, flush, misaligned, badAddr (results).
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            branchTaken;
    logic            jalr;
    logic [XLEN-1:0] exPC;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] imm;
    logic            trapValid;
    logic [XLEN-1:0] trapVector;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] linkAddr;
    logic            flush;
    logic            misaligned;
    logic [XLEN-1:0] badAddr;

    modport master (
        output stall, branchTaken, jalr, exPC, rs1, imm, trapValid, trapVector,
        input  PC, linkAddr, flush, misaligned, badAddr
    );

    modport slave (
        input  stall, branchTaken, jalr, exPC, rs1, imm, trapValid, trapVector,
        output PC, linkAddr, flush, misaligned, badAddr
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: registered fetch PC with sequential advance, branch/JALR/trap
// redirects, a pending-redirect buffer that survives stalls, target
// alignment checking and a one-cycle flush pulse for the front end.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - pc_unit_if.slave: redirect requests in, PC/linkAddr/flush/
//            misaligned/badAddr out
module pc_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                IALIGN       = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_unit_if.slave bus
);
    localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(IALIGN - 1));

    typedef enum logic {RUN, PEND} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] bad_q, bad_d;
    logic            flush_q, flush_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] br_tgt, jalr_tgt, redir_tgt, trap_tgt;
    logic            redir, redir_ok;

    // jalr outranks branchTaken if both are (illegally) asserted together
    assign br_tgt    = bus.exPC + bus.imm;
    assign jalr_tgt  = (bus.rs1 + bus.imm) & ~XLEN'(1);
    assign redir     = bus.jalr | bus.branchTaken;
    assign redir_tgt = bus.jalr ? jalr_tgt : br_tgt;
    assign redir_ok  = (IALIGN == 4) ? (redir_tgt[1:0] == 2'b00) : !redir_tgt[0];
    assign trap_tgt  = bus.trapVector & ALIGN_MASK;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.trapValid)
            state_d = RUN;
        else if (redir && redir_ok)
            state_d = bus.stall ? PEND : RUN;
        else if (state_q == PEND && !bus.stall)
            state_d = RUN;
    end

    // output / datapath next values
    always_comb begin
        pc_d    = pc_q;
        pend_d  = pend_q;
        bad_d   = bad_q;
        flush_d = 1'b0;
        mis_d   = 1'b0;
        if (bus.trapValid) begin
            // trap ignores stall and drops any buffered redirect
            pc_d    = trap_tgt;
            pend_d  = '0;
            flush_d = 1'b1;
        end else begin
            if (redir && !redir_ok) begin
                mis_d = 1'b1;
                bad_d = redir_tgt;
            end
            if (redir && redir_ok) begin
                // newest redirect always replaces the buffered one
                pend_d = redir_tgt;
                if (!bus.stall) begin
                    pc_d    = redir_tgt;
                    flush_d = 1'b1;
                end
            end else if (state_q == PEND) begin
                if (!bus.stall) begin
                    pc_d    = pend_q;
                    flush_d = 1'b1;
                end
            end else if (!bus.stall) begin
                pc_d = pc_q + STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            pend_q  <= '0;
            bad_q   <= '0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            bad_q   <= bad_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.linkAddr   = bus.exPC + XLEN'(4);
    assign bus.flush      = flush_q;
    assign bus.misaligned = mis_q;
    assign bus.badAddr    = bad_q;
endmodule
